// File: rtl/bp_pkg.sv
// Shared types and constants for the branch-resolution slice of the pipeline.
// The tracking entry travels with each fetched instruction from IF to EX so
// that EX can judge the prediction made for it at fetch time.
package bp_pkg;

   // Sequential fetch step: every instruction is one 32-bit word.
   localparam logic [31:0] PC_STEP = 32'd4;

   // Two-bit saturating counter states used by the fetch-side PHT.
   typedef enum logic [1:0] {
      BP_SN = 2'b00,
      BP_WN = 2'b01,
      BP_WT = 2'b10,
      BP_ST = 2'b11
   } bp_state_t;

   // One tracking entry: 1 + 32 + 1 + 32 = 66 bits.
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        pred_taken;
      logic [31:0] pred_pc;
   } bp_track_t;

   // An empty slot. All fields are zeroed, not just valid, so that an empty
   // EX slot presents zeros on every output derived from the entry.
   localparam bp_track_t BP_TRACK_EMPTY = '0;

   // Fall-through address of an instruction; wraps naturally mod 2^32.
   function automatic logic [31:0] bp_next_pc(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/bp_track_reg.sv
// One pipeline tracking register. It can be flushed (clear), held in place
// (hold) or loaded with an empty slot (bubble); otherwise it takes d_in.
// Flush wins over hold so that a mispredict always squashes wrong-path work,
// and hold wins over bubble so a stalled stage keeps its instruction.
module bp_track_reg
   import bp_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      hold,
   input  logic      clear,
   input  logic      bubble,
   input  bp_track_t d_in,
   output bp_track_t q
);

   bp_track_t entry_d;
   bp_track_t entry_q;

   // Select what this stage holds next cycle from the pipeline controls.
   always_comb begin
      entry_d = d_in;
      if (clear) begin
         entry_d = BP_TRACK_EMPTY;
      end else if (hold) begin
         entry_d = entry_q;
      end else if (bubble) begin
         entry_d = BP_TRACK_EMPTY;
      end
   end

   // State register; reset empties the slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         entry_q <= BP_TRACK_EMPTY;
      end else begin
         entry_q <= entry_d;
      end
   end

   assign q = entry_q;

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution. Tracks each fetched instruction's prediction
// through IF/ID and ID/EX, compares the predicted next PC with the resolved
// one in EX, trains the predictor, raises the flush/redirect on a mispredict
// and counts resolved control flow and mispredicts.
module branch_resolve
   import bp_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             if_valid,
   input  logic [31:0]      if_pc,
   input  logic             if_prediction,
   input  logic [31:0]      if_predicted_pc,
   input  logic             stall_if_id,
   input  logic             bubble_id_ex,
   input  logic             ex_is_control_flow,
   input  logic             ex_taken,
   input  logic [31:0]      ex_target,
   output logic             is_control_flow,
   output logic             is_correct,
   output logic [31:0]      pc_to_update,
   output logic [31:0]      branch_target,
   output logic             mispredict,
   output logic [31:0]      redirect_pc,
   output logic [CNT_W-1:0] cf_count,
   output logic [CNT_W-1:0] mispredict_count
);

   bp_track_t        if_entry;
   bp_track_t        id_e;
   bp_track_t        ex_e;
   logic [31:0]      actual_pc;
   logic             pred_hit;
   logic [CNT_W-1:0] cf_count_d;
   logic [CNT_W-1:0] cf_count_q;
   logic [CNT_W-1:0] mispredict_count_d;
   logic [CNT_W-1:0] mispredict_count_q;

   // Package the fetch-slot prediction into a tracking entry.
   always_comb begin
      if_entry = '{valid:      if_valid,
                   pc:         if_pc,
                   pred_taken: if_prediction,
                   pred_pc:    if_predicted_pc};
   end

   // IF/ID entry: held on a load-use stall, squashed on a mispredict.
   bp_track_reg u_id_reg (
      .clk    (clk),
      .reset  (reset),
      .hold   (stall_if_id),
      .clear  (mispredict),
      .bubble (1'b0),
      .d_in   (if_entry),
      .q      (id_e)
   );

   // ID/EX entry: receives a bubble from the hazard unit, squashed on a mispredict.
   bp_track_reg u_ex_reg (
      .clk    (clk),
      .reset  (reset),
      .hold   (1'b0),
      .clear  (mispredict),
      .bubble (bubble_id_ex),
      .d_in   (id_e),
      .q      (ex_e)
   );

   // Resolve the instruction in EX and drive training and redirect outputs.
   always_comb begin
      actual_pc       = (ex_is_control_flow && ex_taken) ? ex_target : bp_next_pc(ex_e.pc);
      pred_hit        = (ex_e.pred_pc == actual_pc);
      is_control_flow = 1'b0;
      is_correct      = 1'b0;
      mispredict      = 1'b0;
      redirect_pc     = 32'd0;
      pc_to_update    = ex_e.pc;
      branch_target   = ex_target;
      if (ex_e.valid) begin
         is_control_flow = ex_is_control_flow;
         is_correct      = pred_hit;
         mispredict      = !pred_hit;
         redirect_pc     = actual_pc;
      end
   end

   // A not-taken prediction from the predictor always points at the fall-through.
   always_comb begin
      if (ex_e.valid && !ex_e.pred_taken) begin
         notTakenIsFallThrough: assert (ex_e.pred_pc == bp_next_pc(ex_e.pc));
      end
   end

   // Counter increments; both wrap with no saturation.
   always_comb begin
      cf_count_d         = cf_count_q + CNT_W'(is_control_flow);
      mispredict_count_d = mispredict_count_q + CNT_W'(mispredict);
   end

   // Performance counter registers; reset clears them even during a mispredict.
   always_ff @(posedge clk) begin
      if (reset) begin
         cf_count_q         <= '0;
         mispredict_count_q <= '0;
      end else begin
         cf_count_q         <= cf_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign cf_count         = cf_count_q;
   assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with 4-bit counters so wrap is reachable.
// Inputs change #1 after each rising edge; outputs are checked before the next edge.
module tb_branch_resolve;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             if_valid;
   logic [31:0]      if_pc;
   logic             if_prediction;
   logic [31:0]      if_predicted_pc;
   logic             stall_if_id;
   logic             bubble_id_ex;
   logic             ex_is_control_flow;
   logic             ex_taken;
   logic [31:0]      ex_target;
   logic             is_control_flow;
   logic             is_correct;
   logic [31:0]      pc_to_update;
   logic [31:0]      branch_target;
   logic             mispredict;
   logic [31:0]      redirect_pc;
   logic [CNT_W-1:0] cf_count;
   logic [CNT_W-1:0] mispredict_count;

   int numChecks = 0;
   int numFails  = 0;

   branch_resolve #(.CNT_W(CNT_W)) dut (
      .clk                (clk),
      .reset              (reset),
      .if_valid           (if_valid),
      .if_pc              (if_pc),
      .if_prediction      (if_prediction),
      .if_predicted_pc    (if_predicted_pc),
      .stall_if_id        (stall_if_id),
      .bubble_id_ex       (bubble_id_ex),
      .ex_is_control_flow (ex_is_control_flow),
      .ex_taken           (ex_taken),
      .ex_target          (ex_target),
      .is_control_flow    (is_control_flow),
      .is_correct         (is_correct),
      .pc_to_update       (pc_to_update),
      .branch_target      (branch_target),
      .mispredict         (mispredict),
      .redirect_pc        (redirect_pc),
      .cf_count           (cf_count),
      .mispredict_count   (mispredict_count)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // The hazard unit never stalls without a bubble; note it if the bench does.
   always @(posedge clk) begin
      if (reset === 1'b0 && stall_if_id === 1'b1 && bubble_id_ex === 1'b0) begin
         $display("[TB] warning: stall_if_id without bubble_id_ex at %0t", $time);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      numChecks++;
      if (observed !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic pt,
                                input logic [31:0] ppc, input logic stall, input logic bub,
                                input logic cf, input logic tk, input logic [31:0] tgt);
      if_valid           = v;
      if_pc              = pc;
      if_prediction      = pt;
      if_predicted_pc    = ppc;
      stall_if_id        = stall;
      bubble_id_ex       = bub;
      ex_is_control_flow = cf;
      ex_taken           = tk;
      ex_target          = tgt;
      #1;
   endtask

   task automatic applyIdle();
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      applyIdle();
      for (int i = 0; i < 3; i++) tick();
   endtask

   initial begin
      reset = 1'b1;
      applyIdle();
      tick();
      tick();
      reset = 1'b0;

      // Idle after reset: everything quiet, counters at zero.
      for (int i = 0; i < 5; i++) begin
         applyIdle();
         checkOutput("idle_mispredict", {31'd0, mispredict}, 32'd0);
         checkOutput("idle_cf", {31'd0, is_control_flow}, 32'd0);
         checkOutput("idle_correct", {31'd0, is_correct}, 32'd0);
         checkOutput("idle_redirect", redirect_pc, 32'd0);
         checkOutput("idle_pc_upd", pc_to_update, 32'd0);
         checkOutput("idle_cf_count", {28'd0, cf_count}, 32'd0);
         checkOutput("idle_mp_count", {28'd0, mispredict_count}, 32'd0);
         tick();
      end

      // Correctly predicted not-taken beq at 0x40, EX two cycles after fetch.
      applyStimulus(1'b1, 32'h40, 1'b0, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      applyStimulus(1'b1, 32'h44, 1'b0, 32'h48, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      applyStimulus(1'b1, 32'h48, 1'b0, 32'h4C, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80);
      checkOutput("nt_cf", {31'd0, is_control_flow}, 32'd1);
      checkOutput("nt_correct", {31'd0, is_correct}, 32'd1);
      checkOutput("nt_mispredict", {31'd0, mispredict}, 32'd0);
      checkOutput("nt_pc_upd", pc_to_update, 32'h40);
      checkOutput("nt_redirect", redirect_pc, 32'h44);
      tick();
      applyIdle();
      checkOutput("nt_cf_count", {28'd0, cf_count}, 32'd1);
      checkOutput("nt_seq_mispredict", {31'd0, mispredict}, 32'd0);
      checkOutput("nt_seq_pc_upd", pc_to_update, 32'h44);
      drain();

      // Taken beq predicted not-taken: flush and redirect to 0x80.
      applyStimulus(1'b1, 32'h40, 1'b0, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      applyStimulus(1'b1, 32'h44, 1'b0, 32'h48, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      applyStimulus(1'b1, 32'h48, 1'b0, 32'h4C, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
      checkOutput("tk_mispredict", {31'd0, mispredict}, 32'd1);
      checkOutput("tk_redirect", redirect_pc, 32'h80);
      checkOutput("tk_pc_upd", pc_to_update, 32'h40);
      checkOutput("tk_target", branch_target, 32'h80);
      checkOutput("tk_cf", {31'd0, is_control_flow}, 32'd1);
      checkOutput("tk_correct", {31'd0, is_correct}, 32'd0);
      tick();
      applyStimulus(1'b1, 32'h80, 1'b0, 32'h84, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("tk_flush_mispredict", {31'd0, mispredict}, 32'd0);
      checkOutput("tk_flush_cf", {31'd0, is_control_flow}, 32'd0);
      checkOutput("tk_flush_pc_upd", pc_to_update, 32'd0);
      checkOutput("tk_cf_count", {28'd0, cf_count}, 32'd2);
      checkOutput("tk_mp_count", {28'd0, mispredict_count}, 32'd1);
      tick();
      applyIdle();
      checkOutput("tk_young_squashed", pc_to_update, 32'd0);
      checkOutput("tk_young_mispredict", {31'd0, mispredict}, 32'd0);
      tick();
      checkOutput("tk_refetch_pc_upd", pc_to_update, 32'h80);
      checkOutput("tk_refetch_mispredict", {31'd0, mispredict}, 32'd0);
      drain();

      // BTB alias: add at 0x10 predicted taken to 0x100.
      applyStimulus(1'b1, 32'h10, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      applyIdle();
      tick();
      applyIdle();
      checkOutput("alias_mispredict", {31'd0, mispredict}, 32'd1);
      checkOutput("alias_redirect", redirect_pc, 32'h14);
      checkOutput("alias_cf", {31'd0, is_control_flow}, 32'd0);
      checkOutput("alias_pc_upd", pc_to_update, 32'h10);
      tick();
      checkOutput("alias_mp_count", {28'd0, mispredict_count}, 32'd2);
      checkOutput("alias_cf_count", {28'd0, cf_count}, 32'd2);
      drain();

      // Load-use stall with bubble on a jal at 0x20 predicted to 0x60.
      applyStimulus(1'b1, 32'h20, 1'b1, 32'h60, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      applyStimulus(1'b1, 32'h24, 1'b0, 32'h28, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      tick();
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h60);
      checkOutput("stall_bubble_cf", {31'd0, is_control_flow}, 32'd0);
      checkOutput("stall_bubble_mispredict", {31'd0, mispredict}, 32'd0);
      checkOutput("stall_bubble_pc_upd", pc_to_update, 32'd0);
      tick();
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h60);
      checkOutput("jal_cf", {31'd0, is_control_flow}, 32'd1);
      checkOutput("jal_correct", {31'd0, is_correct}, 32'd1);
      checkOutput("jal_mispredict", {31'd0, mispredict}, 32'd0);
      checkOutput("jal_pc_upd", pc_to_update, 32'h20);
      tick();
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h60);
      checkOutput("jal_once_cf", {31'd0, is_control_flow}, 32'd0);
      checkOutput("jal_cf_count", {28'd0, cf_count}, 32'd3);
      tick();
      checkOutput("jal_once_cf_count", {28'd0, cf_count}, 32'd3);
      checkOutput("jal_mp_count", {28'd0, mispredict_count}, 32'd2);
      drain();

      // Counter wrap: 17 correctly predicted not-taken branches from reset.
      reset = 1'b1;
      applyIdle();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 19; i++) begin
         applyStimulus(i < 17, 32'h200 + 32'(4 * i), 1'b0, 32'h204 + 32'(4 * i),
                       1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
         tick();
      end
      applyIdle();
      checkOutput("wrap_cf_count", {28'd0, cf_count}, 32'd1);
      checkOutput("wrap_mp_count", {28'd0, mispredict_count}, 32'd0);

      // Reset arriving together with a mispredict clears everything.
      applyStimulus(1'b1, 32'h300, 1'b0, 32'h304, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      applyIdle();
      tick();
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h400);
      checkOutput("rstmp_mispredict", {31'd0, mispredict}, 32'd1);
      checkOutput("rstmp_redirect", redirect_pc, 32'h400);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      applyIdle();
      checkOutput("rstmp_cf_count", {28'd0, cf_count}, 32'd0);
      checkOutput("rstmp_mp_count", {28'd0, mispredict_count}, 32'd0);
      checkOutput("rstmp_after_mispredict", {31'd0, mispredict}, 32'd0);
      checkOutput("rstmp_after_redirect", redirect_pc, 32'd0);
      checkOutput("rstmp_after_cf", {31'd0, is_control_flow}, 32'd0);
      tick();
      checkOutput("rstmp_settled_pc_upd", pc_to_update, 32'd0);
      checkOutput("rstmp_settled_mp_count", {28'd0, mispredict_count}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- EX-stage counterpart to the fetch-side BTB/PHT predictor.
- Carries each fetched instruction's prediction (pc, taken bit, predicted_pc) through internal IF/ID and ID/EX tracking registers that mirror the pipeline, including stalls and bubbles.
- In EX, compares the predicted next PC with the resolved next PC and drives the predictor's training interface (is_control_flow, is_correct, pc_to_update, branch_target).
- Also produces the mispredict flush/redirect and keeps performance counters.

Parameters:
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- if_valid  in  1  fetch slot holds a real instruction this cycle.
- if_pc  in  32  PC being fetched.
- if_prediction  in  1  predictor's taken bit for if_pc.
- if_predicted_pc  in  32  predictor's next PC for if_pc.
- stall_if_id  in  1  hold the IF/ID tracking entry (load-use stall).
- bubble_id_ex  in  1  insert an invalid entry into ID/EX.
- ex_is_control_flow  in  1  instruction in EX is a branch, jal or jalr.
- ex_taken  in  1  resolved direction (1 for jal/jalr).
- ex_target  in  32  resolved taken target.
- is_control_flow  out  1  predictor update strobe.
- is_correct  out  1  prediction was right.
- pc_to_update  out  32  PC of the resolved instruction.
- branch_target  out  32  ex_target, forwarded for BTB fill.
- mispredict  out  1  flush IF/ID and ID/EX; redirect fetch.
- redirect_pc  out  32  correct next PC.
- cf_count  out  CNT_W  resolved control-flow instructions.
- mispredict_count  out  CNT_W  mispredicts, all causes.

Behaviour:
- Tracking entry fields: {valid, pc, pred_taken, pred_pc}. There are two registers, id_e and ex_e.
- Reset (synchronous): id_e.valid=0, ex_e.valid=0, both counters 0. All outputs are then 0 because ex_e is invalid.
- Resolution is combinational from ex_e and the ex_* inputs.
  - actual_pc = (ex_is_control_flow && ex_taken) ? ex_target : ex_e.pc+4. Addition wraps mod 2^32.
  - is_correct = (ex_e.pred_pc == actual_pc).
  - mispredict = ex_e.valid && !is_correct.
  - redirect_pc = actual_pc.
  - is_control_flow = ex_e.valid && ex_is_control_flow.
  - pc_to_update = ex_e.pc; branch_target = ex_target.
- Outputs when ex_e.valid=0: mispredict=0, is_control_flow=0, is_correct=0, redirect_pc=0.
- Non-control-flow instruction predicted taken (BTB alias): mispredict=1 with redirect to pc+4. is_control_flow=0, so no training. Counted in mispredict_count only.
- Predictor latency: the predictor samples the update outputs on the same posedge, so the PHT/BTB change is visible to fetch one cycle after EX.
- Next-state rules, in priority order:
  1. reset.
  2. mispredict=1: id_e.valid<=0 and ex_e.valid<=0. The wrong-path IF capture is discarded. stall_if_id and bubble_id_ex are ignored.
  3. Otherwise ex_e <= bubble_id_ex ? invalid : id_e.
  4. id_e <= stall_if_id ? id_e : {if_valid, if_pc, if_prediction, if_predicted_pc}.
- stall_if_id=1 with bubble_id_ex=0 is legal and duplicates id_e into EX. The hazard unit always asserts both together; the bench flags the case as a warning.
- Counters: cf_count += is_control_flow; mispredict_count += mispredict. Both wrap mod 2^CNT_W with no saturation.
- Reset asserted mid-operation overrides a pending mispredict. Counters clear in the same cycle.
- Back-to-back mispredicts are impossible, since EX is invalid the cycle after a flush. The implementation does not rely on this.

Decomposition:
- Shared package `bp_pkg`:
  - bp_track_t, the entry struct (66 bits);
  - BP_ST/WT/WN/SN encodings, for the predictor;
  - PC_STEP=4.
- One sub-module, `bp_track_reg`: a single tracking register with hold, clear and bubble controls, instantiated twice (id_e, ex_e).

Test Plan:
- Reset, then idle with if_valid=0 for 5 cycles -> all outputs 0 and both counters stay 0.
- Correctly predicted not-taken beq: pc=0x40, pred_pc=0x44, ex_taken=0, reaching EX 2 cycles after fetch -> is_control_flow=1, is_correct=1, mispredict=0, cf_count=1.
- Taken beq predicted not-taken: pc=0x40, pred_pc=0x44, ex_taken=1, ex_target=0x80 -> mispredict=1, redirect_pc=0x80, pc_to_update=0x40, branch_target=0x80. The next cycle has ex_e invalid, and the two younger fetches (0x44, 0x48) never reach EX.
- BTB alias: add at pc=0x10 with pred_taken=1, pred_pc=0x100 -> mispredict=1, redirect_pc=0x14, is_control_flow=0, mispredict_count+1, cf_count unchanged.
- Load-use stall with stall_if_id=1 and bubble_id_ex=1 for 1 cycle on a jal at 0x20 (target 0x60, predicted 0x60) -> ex_e invalid for 1 cycle, then the jal resolves with is_correct=1 exactly once.
- Counter wrap with CNT_W=4: 17 resolved branches -> cf_count=1. Assert reset together with a mispredict -> counters 0 next cycle, with no redirect latched.
